// File: rtl/branch_cmp_unit_if.sv
// Operand/control and result bundle for branch_cmp_unit.
// The BCMP_STATS_EN macro adds the branch and mispredict statistics counters.
interface branch_cmp_unit_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDX_W = 4
);
  logic             stall;
  logic             flush;
  logic             in_valid;
  logic [3:0]       op;
  logic [WIDTH-1:0] D1;
  logic [WIDTH-1:0] D2;
  logic [IDX_W-1:0] idx;
  logic             pred_taken;
  logic             taken;
  logic             nullify;
  logic             res_valid;
  logic             res_taken;
  logic             res_nullify;
  logic             res_mispredict;
`ifdef BCMP_STATS_EN
  logic [31:0]      branch_cnt;
  logic [31:0]      mispredict_cnt;
`endif

  modport master (
    output stall, flush, in_valid, op, D1, D2, idx,
`ifdef BCMP_STATS_EN
    input  branch_cnt, mispredict_cnt,
`endif
    input  pred_taken, taken, nullify, res_valid, res_taken, res_nullify, res_mispredict
  );

  modport slave (
    input  stall, flush, in_valid, op, D1, D2, idx,
`ifdef BCMP_STATS_EN
    output branch_cnt, mispredict_cnt,
`endif
    output pred_taken, taken, nullify, res_valid, res_taken, res_nullify, res_mispredict
  );
endinterface

// File: rtl/branch_cmp_unit.sv
// ID-stage compare / branch-resolution unit with a 2-bit saturating BHT.
// Defining BCMP_STATS_EN adds the saturating branch_cnt / mispredict_cnt counters.
module branch_cmp_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned IDX_W    = 4,
  parameter logic [1:0]  BHT_INIT = 2'b01
) (
  input logic               clk,
  input logic               reset,
  branch_cmp_unit_if.slave  bus
);
  localparam int unsigned Depth = 1 << IDX_W;

  logic [1:0] bht_q [Depth];
  logic [1:0] cnt_cur, bht_nxt;
  logic       is_branch, is_move, acc, bht_we, mis;
  logic       taken_c, nullify_c, pred_c;
  logic       res_valid_q, res_taken_q, res_nullify_q, res_mispredict_q;
  logic       res_valid_d, res_taken_d, res_nullify_d, res_mispredict_d;

  always_comb begin
    is_branch = (bus.op >= 4'd1) && (bus.op <= 4'd6);
    is_move   = (bus.op == 4'd7) || (bus.op == 4'd8);
    taken_c   = 1'b0;
    nullify_c = 1'b0;
    case (bus.op)
      4'd1:    taken_c = (bus.D1 == bus.D2);
      4'd2:    taken_c = (bus.D1 != bus.D2);
      4'd3:    taken_c = bus.D1[WIDTH-1] || (bus.D1 == '0);
      4'd4:    taken_c = !bus.D1[WIDTH-1] && (bus.D1 != '0);
      4'd5:    taken_c = bus.D1[WIDTH-1];
      4'd6:    taken_c = !bus.D1[WIDTH-1];
      4'd7:    nullify_c = (bus.D2 != '0);
      4'd8:    nullify_c = (bus.D2 == '0);
      default: ;
    endcase

    // Prediction and mispredict always see the pre-update counter.
    cnt_cur = bht_q[bus.idx];
    pred_c  = is_branch & cnt_cur[1];
    mis     = is_branch & (taken_c ^ pred_c);
    if (taken_c) begin
      bht_nxt = (cnt_cur == 2'b11) ? cnt_cur : cnt_cur + 2'b01;
    end else begin
      bht_nxt = (cnt_cur == 2'b00) ? cnt_cur : cnt_cur - 2'b01;
    end

    acc    = bus.in_valid & ~bus.stall & ~bus.flush;
    bht_we = acc & is_branch;

    res_valid_d      = res_valid_q;
    res_taken_d      = res_taken_q;
    res_nullify_d    = res_nullify_q;
    res_mispredict_d = res_mispredict_q;
    if (bus.flush || (!bus.stall && !bus.in_valid)) begin
      res_valid_d      = 1'b0;
      res_taken_d      = 1'b0;
      res_nullify_d    = 1'b0;
      res_mispredict_d = 1'b0;
    end else if (acc) begin
      res_valid_d      = is_branch | is_move;
      res_taken_d      = taken_c;
      res_nullify_d    = nullify_c;
      res_mispredict_d = mis;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid_q      <= 1'b0;
      res_taken_q      <= 1'b0;
      res_nullify_q    <= 1'b0;
      res_mispredict_q <= 1'b0;
    end else begin
      res_valid_q      <= res_valid_d;
      res_taken_q      <= res_taken_d;
      res_nullify_q    <= res_nullify_d;
      res_mispredict_q <= res_mispredict_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) bht_q[i] <= BHT_INIT;
    end else if (bht_we) begin
      bht_q[bus.idx] <= bht_nxt;
    end
  end

  assign bus.pred_taken     = pred_c;
  assign bus.taken          = taken_c;
  assign bus.nullify        = nullify_c;
  assign bus.res_valid      = res_valid_q;
  assign bus.res_taken      = res_taken_q;
  assign bus.res_nullify    = res_nullify_q;
  assign bus.res_mispredict = res_mispredict_q;

`ifdef BCMP_STATS_EN
  logic [31:0] branch_cnt_q, branch_cnt_d, mispredict_cnt_q, mispredict_cnt_d;

  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (bht_we && (branch_cnt_q != '1)) branch_cnt_d = branch_cnt_q + 32'd1;
    if (bht_we && mis && (mispredict_cnt_q != '1)) mispredict_cnt_d = mispredict_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.mispredict_cnt = mispredict_cnt_q;
`endif
endmodule

// File: tb/tb_branch_cmp_unit.sv
// Directed, table-driven bench for branch_cmp_unit plus stall/flush/reset sequences.
module tb_branch_cmp_unit;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  branch_cmp_unit_if #(.WIDTH(32), .IDX_W(4)) bus ();

  branch_cmp_unit #(.WIDTH(32), .IDX_W(4), .BHT_INIT(2'b01)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [3:0]  idx;
    logic        v, st, fl;
    logic        ep, et, en;
    logic        erv, ert, ern, erm;
    logic [1:0]  eb;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic [3:0] op, logic [31:0] d1, logic [31:0] d2, logic [3:0] idx,
                              logic v, logic st, logic fl, logic ep, logic et, logic en,
                              logic erv, logic ert, logic ern, logic erm, logic [1:0] eb);
    vec_t t;
    t.op = op; t.d1 = d1; t.d2 = d2; t.idx = idx; t.v = v; t.st = st; t.fl = fl;
    t.ep = ep; t.et = et; t.en = en; t.erv = erv; t.ert = ert; t.ern = ern; t.erm = erm;
    t.eb = eb;
    tbl.push_back(t);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic [3:0] op, logic [31:0] d1, logic [31:0] d2, logic [3:0] idx,
                       logic v, logic st, logic fl);
    bus.op = op; bus.D1 = d1; bus.D2 = d2; bus.idx = idx;
    bus.in_valid = v; bus.stall = st; bus.flush = fl;
  endtask

  task automatic chk_res(string name, logic rv, logic rt, logic rn, logic rm);
    chk({name, ".res_valid"}, {31'd0, bus.res_valid}, {31'd0, rv});
    chk({name, ".res_taken"}, {31'd0, bus.res_taken}, {31'd0, rt});
    chk({name, ".res_nullify"}, {31'd0, bus.res_nullify}, {31'd0, rn});
    chk({name, ".res_mispredict"}, {31'd0, bus.res_mispredict}, {31'd0, rm});
  endtask

  task automatic chk_bht_all_init(string name);
    for (int i = 0; i < 16; i++) chk($sformatf("%s.bht[%0d]", name, i), {30'd0, dut.bht_q[i]},
                                     32'd1);
  endtask

  // Inputs change 1 time unit after the rising edge; checks land 1-2 units after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // op, d1, d2, idx, v, st, fl, pred, taken, null, rv, rt, rn, rm, bht[idx] after edge
    add(4'd1, 32'h1234, 32'h1234, 4'd3, 1, 0, 0, 0, 1, 0, 1, 1, 0, 1, 2'b10);
    add(4'd1, 32'h1234, 32'h1234, 4'd3, 1, 0, 0, 1, 1, 0, 1, 1, 0, 0, 2'b11);
    add(4'd1, 32'h1234, 32'h1234, 4'd3, 1, 0, 0, 1, 1, 0, 1, 1, 0, 0, 2'b11);
    add(4'd5, 32'h80000000, 32'h0, 4'd5, 1, 0, 0, 0, 1, 0, 1, 1, 0, 1, 2'b10);
    add(4'd4, 32'h0, 32'h55, 4'd6, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00);
    add(4'd6, 32'h0, 32'h0, 4'd7, 1, 0, 0, 0, 1, 0, 1, 1, 0, 1, 2'b10);
    add(4'd3, 32'h7FFFFFFF, 32'h0, 4'd8, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00);
    add(4'd4, 32'h0, 32'h0, 4'd6, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00);
    add(4'd7, 32'h0, 32'h5, 4'd3, 1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 2'b11);
    add(4'd8, 32'h0, 32'h0, 4'd3, 1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 2'b11);
    add(4'd7, 32'h0, 32'h0, 4'd3, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b11);
    add(4'd8, 32'h0, 32'h7, 4'd3, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b11);
    add(4'd9, 32'h1, 32'h1, 4'd3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11);
    add(4'd1, 32'h9, 32'h9, 4'd3, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b11);
    add(4'd2, 32'h1, 32'h2, 4'd3, 1, 0, 0, 1, 1, 0, 1, 1, 0, 0, 2'b11);
    add(4'd2, 32'h5, 32'h5, 4'd3, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 2'b10);
    add(4'd1, 32'h1, 32'h2, 4'd3, 1, 1, 0, 1, 0, 0, 1, 0, 0, 1, 2'b10);
    add(4'd1, 32'h4, 32'h4, 4'd3, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 2'b10);

    drive(4'd0, 32'h0, 32'h0, 4'd0, 0, 0, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_res("reset", 0, 0, 0, 0);
    chk_bht_all_init("reset");
    reset = 1'b0;

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].op, tbl[k].d1, tbl[k].d2, tbl[k].idx, tbl[k].v, tbl[k].st, tbl[k].fl);
      #1;
      chk($sformatf("v%0d.pred_taken", k), {31'd0, bus.pred_taken}, {31'd0, tbl[k].ep});
      chk($sformatf("v%0d.taken", k), {31'd0, bus.taken}, {31'd0, tbl[k].et});
      chk($sformatf("v%0d.nullify", k), {31'd0, bus.nullify}, {31'd0, tbl[k].en});
      step();
      chk_res($sformatf("v%0d", k), tbl[k].erv, tbl[k].ert, tbl[k].ern, tbl[k].erm);
      chk($sformatf("v%0d.bht", k), {30'd0, dut.bht_q[tbl[k].idx]}, {30'd0, tbl[k].eb});
    end

    // Accepted BNE, then a 3-cycle stall with a different branch presented.
    drive(4'd2, 32'h1, 32'h2, 4'd9, 1, 0, 0);
    step();
    chk_res("bne", 1, 1, 0, 1);
    chk("bne.bht9", {30'd0, dut.bht_q[9]}, 32'd2);
    for (int s = 0; s < 3; s++) begin
      drive(4'd1, 32'h4, 32'h5, 4'd9, 1, 1, 0);
      step();
      chk_res($sformatf("stall%0d", s), 1, 1, 0, 1);
      chk($sformatf("stall%0d.bht9", s), {30'd0, dut.bht_q[9]}, 32'd2);
    end
    drive(4'd1, 32'h4, 32'h5, 4'd9, 1, 1, 1);
    step();
    chk_res("flush_in_stall", 0, 0, 0, 0);
    chk("flush_in_stall.bht9", {30'd0, dut.bht_q[9]}, 32'd2);

    // Asynchronous reset between edges while a result is held.
    drive(4'd1, 32'h7, 32'h7, 4'd10, 1, 0, 0);
    step();
    chk_res("pre_reset", 1, 1, 0, 1);
    drive(4'd1, 32'h7, 32'h7, 4'd10, 1, 1, 0);
    #2 reset = 1'b1;
    #1;
    chk_res("async_reset", 0, 0, 0, 0);
    chk_bht_all_init("async_reset");
`ifdef BCMP_STATS_EN
    chk("async_reset.branch_cnt", bus.branch_cnt, 32'd0);
    chk("async_reset.mispredict_cnt", bus.mispredict_cnt, 32'd0);
`endif
    #1 reset = 1'b0;
    drive(4'd0, 32'h0, 32'h0, 4'd0, 0, 0, 0);
    step();

    // Four branches, exactly one mispredict.
    drive(4'd1, 32'h3, 32'h3, 4'd0, 1, 0, 0);
    step();
    chk_res("st0", 1, 1, 0, 1);
    drive(4'd1, 32'h3, 32'h3, 4'd0, 1, 0, 0);
    step();
    chk_res("st1", 1, 1, 0, 0);
    drive(4'd2, 32'h5, 32'h5, 4'd1, 1, 0, 0);
    step();
    chk_res("st2", 1, 0, 0, 0);
    drive(4'd4, 32'h0, 32'h0, 4'd1, 1, 0, 0);
    step();
    chk_res("st3", 1, 0, 0, 0);
    chk("st3.bht0", {30'd0, dut.bht_q[0]}, 32'd3);
    chk("st3.bht1", {30'd0, dut.bht_q[1]}, 32'd0);
    drive(4'd7, 32'h0, 32'h0, 4'd1, 1, 0, 0);
    step();
`ifdef BCMP_STATS_EN
    chk("stats.branch_cnt", bus.branch_cnt, 32'd4);
    chk("stats.mispredict_cnt", bus.mispredict_cnt, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
